// File: rtl/ascon_permutation_ctrl.sv
// Ascon permutation sequencer: holds the 320-bit state and applies one full
// round (constant addition, substitution, linear diffusion) per clock for a
// requested number of rounds, always finishing on the last round index.
module ascon_permutation_ctrl #(
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [3:0]           i_num_rounds,
  input  logic [0:4][63:0]     i_state,
  output logic [0:4][63:0]     o_state,
  output logic [3:0]           o_round,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [3:0] MAX_R  = 4'(MAX_ROUNDS);
  localparam logic [3:0] LAST_R = 4'(MAX_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_t;

  fsm_t             cur_st, nxt_st;
  logic [0:4][63:0] state_reg, state_nxt;
  logic [0:4][63:0] add_out, sub_out, dif_out;
  logic [3:0]       round_reg, round_nxt;
  logic [3:0]       n_clamped;

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Bitsliced 5-bit S-box applied to all 64 columns at once
  function automatic logic [0:4][63:0] substitution(input logic [0:4][63:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [0:4][63:0] diffusion(input logic [0:4][63:0] s);
    logic [0:4][63:0] d;
    d[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
    d[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
    d[2] = s[2] ^ ror(s[2],  1) ^ ror(s[2],  6);
    d[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
    d[4] = s[4] ^ ror(s[4],  7) ^ ror(s[4], 41);
    return d;
  endfunction

  // Round datapath: constant is {15-r, r} XORed into the low byte of word 2
  always_comb begin
    add_out          = state_reg;
    add_out[2][7:0]  = state_reg[2][7:0] ^ {~round_reg, round_reg};
    sub_out          = substitution(add_out);
    dif_out          = diffusion(sub_out);
  end

  assign n_clamped = (i_num_rounds > MAX_R) ? MAX_R : i_num_rounds;

  // Next-state, next round index and next state-register contents
  always_comb begin
    nxt_st    = cur_st;
    round_nxt = round_reg;
    state_nxt = state_reg;
    case (cur_st)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = i_state;
          round_nxt = MAX_R - n_clamped;
          nxt_st    = (n_clamped == 4'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        state_nxt = dif_out;
        if (round_reg == LAST_R) begin
          nxt_st = S_DONE;
        end else begin
          round_nxt = round_reg + 4'd1;
        end
      end
      S_DONE: begin
        nxt_st    = S_IDLE;
        round_nxt = '0;
      end
      default: nxt_st = S_IDLE;
    endcase
  end

  // State, round counter and FSM registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_st    <= S_IDLE;
      round_reg <= '0;
      state_reg <= '0;
    end else begin
      cur_st    <= nxt_st;
      round_reg <= round_nxt;
      state_reg <= state_nxt;
    end
  end

  assign o_state = state_reg;
  assign o_round = round_reg;
  assign o_busy  = (cur_st == S_RUN);
  assign o_done  = (cur_st == S_DONE);

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Self-checking bench for ascon_permutation_ctrl against a table-driven
// Ascon reference permutation.
module tb_ascon_permutation_ctrl;

  typedef logic [0:4][63:0] st_t;

  logic       clock;
  logic       reset;
  logic       i_start;
  logic [3:0] i_num_rounds;
  st_t        i_state;
  st_t        o_state;
  logic [3:0] o_round;
  logic       o_busy;
  logic       o_done;

  int unsigned n_checks;
  int unsigned n_bad;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  ascon_permutation_ctrl #(.MAX_ROUNDS(12)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_start      (i_start),
    .i_num_rounds (i_num_rounds),
    .i_state      (i_state),
    .o_state      (o_state),
    .o_round      (o_round),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    logic [127:0] d;
    d = {v, v};
    return d[n +: 64];
  endfunction

  // Reference: rounds 12-N .. 11, S-box looked up column by column
  function automatic st_t ref_perm(input st_t s, input int unsigned n);
    st_t         x;
    st_t         y;
    int unsigned nc;
    logic [4:0]  v;
    logic [4:0]  o;
    x  = s;
    nc = (n > 12) ? 12 : n;
    for (int unsigned r = 12 - nc; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int unsigned j = 0; j < 64; j++) begin
        v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o = SBOX[v];
        x[0][j] = o[4]; x[1][j] = o[3]; x[2][j] = o[2]; x[3][j] = o[1]; x[4][j] = o[0];
      end
      y[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      y[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      y[2] = x[2] ^ rotr(x[2],  1) ^ rotr(x[2],  6);
      y[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      y[4] = x[4] ^ rotr(x[4],  7) ^ rotr(x[4], 41);
      x = y;
    end
    return x;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int unsigned i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one start and follows it cycle by cycle to the return to IDLE;
  // ends at the earliest point a following start may be driven.
  task automatic run_perm(input st_t s, input int unsigned n, input int inject_at);
    st_t         exp;
    int unsigned nc;
    exp = ref_perm(s, n);
    nc  = (n > 12) ? 12 : n;
    i_start      = 1'b1;
    i_num_rounds = 4'(n);
    i_state      = s;
    tick();
    i_start = 1'b0;
    i_state = rand_state();
    for (int unsigned k = 0; k < nc; k++) begin
      check("round", 320'(o_round), 320'(12 - nc + k));
      check("busy_run", 320'(o_busy), 320'd1);
      check("done_early", 320'(o_done), 320'd0);
      if (int'(k) == inject_at) begin
        i_start      = 1'b1;
        i_num_rounds = 4'd12;
        i_state      = rand_state();
      end
      tick();
      i_start = 1'b0;
    end
    check("done", 320'(o_done), 320'd1);
    check("busy_done", 320'(o_busy), 320'd0);
    check("round_done", 320'(o_round), 320'(nc == 0 ? 12 : 11));
    check("result", o_state, exp);
    tick();
    check("done_clear", 320'(o_done), 320'd0);
    check("state_hold", o_state, exp);
    check("round_idle", 320'(o_round), 320'd0);
  endtask

  initial begin
    st_t s;
    n_checks     = 0;
    n_bad        = 0;
    reset        = 1'b0;
    i_start      = 1'b0;
    i_num_rounds = '0;
    i_state      = '0;

    // Asynchronous reset before the first clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_state", o_state, '0);
    check("rst_round", 320'(o_round), 320'd0);
    check("rst_busy", 320'(o_busy), 320'd0);
    check("rst_done", 320'(o_done), 320'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_busy", 320'(o_busy), 320'd0);
    check("idle_done", 320'(o_done), 320'd0);

    // p^12 on the Ascon-128 IV-style state
    s = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'h0};
    run_perm(s, 12, -1);

    // p^6, then boundary counts
    run_perm(rand_state(), 6, -1);
    run_perm(rand_state(), 0, -1);
    run_perm(rand_state(), 1, -1);
    s = rand_state();
    run_perm(s, 15, -1);
    run_perm(s, 12, -1);

    // Start pulsed mid-run is ignored
    run_perm(rand_state(), 12, 3);

    // Back-to-back at the earliest legal edge, then random counts
    run_perm(rand_state(), 6, -1);
    run_perm(rand_state(), 6, -1);
    for (int unsigned i = 0; i < 8; i++) begin
      run_perm(rand_state(), $urandom_range(15, 0), -1);
    end

    // Reset during round 5 of p^12 discards the run
    i_start      = 1'b1;
    i_num_rounds = 4'd12;
    i_state      = rand_state();
    tick();
    i_start = 1'b0;
    for (int unsigned k = 0; k < 5; k++) tick();
    check("pre_abort_round", 320'(o_round), 320'd5);
    #2 reset = 1'b1;
    #1;
    check("abort_state", o_state, '0);
    check("abort_round", 320'(o_round), 320'd0);
    check("abort_busy", 320'(o_busy), 320'd0);
    check("abort_done", 320'(o_done), 320'd0);
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check("abort_no_done", 320'(o_done), 320'd0);
    end
    reset = 1'b0;
    for (int unsigned k = 0; k < 14; k++) begin
      tick();
      check("post_abort_no_done", 320'(o_done), 320'd0);
      check("post_abort_idle", 320'(o_busy), 320'd0);
    end
    run_perm(rand_state(), 6, -1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
